ring_monitor: RTL and testbench
===============================

# ring_monitor

Receive-side checker for the 4-bit ring-counter output bus. It samples the ring word each enabled cycle and checks that it is one-hot and advances by exactly one left rotation per sample. It decodes the hot bit to a binary index, declares lock after a run of correct steps, and counts sequence errors once locked. It sits downstream of the ring counter and is used in-system and in benches to qualify ring-counter behaviour.

## Interface
- WIDTH, 4, ring word width (≥2)
- LOCK_CNT, 2, consecutive correct rotations required to assert lock (≥1)
- ERR_W, 8, error counter width
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset (one clock; reset asynchronous and active-low)
- en  input  1  sample enable; ring_in is ignored when 0
- ring_in  input  WIDTH  ring-counter word under check
- clr_err  input  1  synchronous clear of err_cnt
- idx  output  $clog2(WIDTH)  binary index of last valid one-hot sample
- onehot_ok  output  1  last sample was one-hot
- locked  output  1  monitor is locked to a correct rotation sequence
- err_pulse  output  1  one-cycle pulse per sequence error while locked
- err_cnt  output  ERR_W  saturating count of sequence errors

## Operation
- Expected next word: rot(p) = {p[WIDTH-2:0], p[WIDTH-1]}, a left rotate. Example for 4 bits: 0001→0010→0100→1000→0001.
- One-hot means exactly one bit is set. All-zero and multi-bit words are invalid.
- Internal state: prev (last one-hot sample), good_cnt, FSM state ∈ {HUNT, TRACK, LOCKED}.
- All actions below occur only on edges where en=1. With en=0, all state and outputs hold, and err_pulse is 0.
- HUNT:
  - One-hot sample: prev←sample, good_cnt←0, go to TRACK.
  - Invalid sample: stay in HUNT.
  - No error is counted.
- TRACK:
  - Sample == rot(prev): prev←sample, good_cnt++. If the new good_cnt == LOCK_CNT, go to LOCKED.
  - One-hot but not rot(prev): restart. prev←sample, good_cnt←0, stay in TRACK, no error.
  - Invalid sample: go to HUNT, no error.
- LOCKED:
  - Sample == rot(prev): prev←sample, stay in LOCKED.
  - Any other sample: err_pulse=1 for one cycle and err_cnt increments, saturating at 2^ERR_W−1.
    - If the sample is one-hot: prev←sample, good_cnt←0, go to TRACK.
    - Otherwise: go to HUNT.
- A repeated (stalled) word is a mismatch and is treated as an error when locked.
- idx updates only on one-hot samples and holds its last value on invalid samples.
- onehot_ok is updated on every enabled sample.
- clr_err=1 forces err_cnt to 0 and has priority over a same-cycle increment. err_pulse still fires on that cycle.
- WIDTH=1 is unsupported.

## Timing
- All outputs are registered. An enabled sample at edge N is reflected in the outputs after edge N (visible during cycle N+1). Latency is 1 cycle.
- locked asserts on the edge of the LOCK_CNT-th correct rotation. With LOCK_CNT=2, the first one-hot sample is at edge k and locked=1 after edge k+2.
- locked deasserts on the same edge that raises err_pulse.
- err_pulse is high for exactly one cycle per error edge, including on back-to-back error edges.
- Reset (rst=0), asynchronous and effective mid-operation:
  - state=HUNT, prev=0, good_cnt=0.
  - idx=0, onehot_ok=0, locked=0, err_pulse=0, err_cnt=0.
  - After rst rises, the first enabled edge is processed normally.
- Saturation: at err_cnt=2^ERR_W−1 a further error leaves err_cnt unchanged but still pulses err_pulse.

## Test plan
All scenarios use WIDTH=4, LOCK_CNT=2, ERR_W=8.
- Lock acquisition: rst low, release, en=1, ring_in 0000 for 2 cycles then 0001, 0010, 0100, 1000 → locked=0 through the 0010 sample, locked=1 after the 0100 edge; idx sequence 0,1,2,3; err_cnt=0.
- Sequence error: locked on 0001→0010, then drive 1000 → one err_pulse, err_cnt=1, locked=0, state TRACK; then 0001, 0010 → locked=1 again.
- Invalid word while locked: locked, drive 0110 → err_pulse, err_cnt=1, onehot_ok=0, idx holds; next 0001, 0010, 0100 → relock after 0100.
- Enable gating and stall: locked at 0100, en=0 for 5 cycles with ring_in changing → no output change; en=1 with 0100 repeated → err_pulse, err_cnt=1.
- Counter priority and saturation: force 255 errors → err_cnt=255; one more error → err_cnt stays 255, err_pulse=1; error with clr_err=1 on the same cycle → err_cnt=0.
- Async reset mid-lock: assert rst between clock edges while locked with err_cnt=3 → all outputs 0 immediately, without waiting for a clock edge; relock after reset takes the full LOCK_CNT sequence.

Source files
------------

// File: rtl/ring_monitor.sv
// ring_monitor
// Receive-side checker for a WIDTH-bit ring-counter bus. Each enabled cycle
// the ring word is sampled and checked for being one-hot and for advancing by
// exactly one left rotation from the previous one-hot sample. After LOCK_CNT
// consecutive correct rotations the monitor declares lock; once locked, every
// wrong sample raises a one-cycle err_pulse and bumps a saturating counter.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   en        in   sample enable; ring_in ignored and all state held when 0
//   ring_in   in   [WIDTH-1:0] ring-counter word under check
//   clr_err   in   synchronous clear of err_cnt (wins over an increment)
//   idx       out  [$clog2(WIDTH)-1:0] binary index of last one-hot sample
//   onehot_ok out  last enabled sample was one-hot
//   locked    out  monitor is locked to a correct rotation sequence
//   err_pulse out  one-cycle pulse per sequence error while locked
//   err_cnt   out  [ERR_W-1:0] saturating count of sequence errors
module ring_monitor #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 2,
    parameter int ERR_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [WIDTH-1:0]           ring_in,
    input  logic                       clr_err,
    output logic [$clog2(WIDTH)-1:0]   idx,
    output logic                       onehot_ok,
    output logic                       locked,
    output logic                       err_pulse,
    output logic [ERR_W-1:0]           err_cnt
);

    localparam int IDX_W  = $clog2(WIDTH);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
    function automatic logic is_onehot(input logic [WIDTH-1:0] w);
        return (w != {WIDTH{1'b0}}) && ((w & (w - WIDTH'(1))) == {WIDTH{1'b0}});
    endfunction

    // Binary position of the set bit; only meaningful for one-hot inputs.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [WIDTH-1:0] w);
        logic [IDX_W-1:0] r;
        r = {IDX_W{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            if (w[i]) begin
                r = IDX_W'(i);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    prev_q, prev_d;
    logic [GOOD_W-1:0]   good_cnt_q, good_cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                onehot_ok_q, onehot_ok_d;
    logic                locked_q, locked_d;
    logic                err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;

    logic                sample_oh_s;
    logic                match_s;
    logic                seq_err_s;
    logic [GOOD_W-1:0]   good_inc_s;
    logic [WIDTH-1:0]    expect_s;

    // Expected word and per-sample classification.
    always_comb begin
        expect_s    = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
        sample_oh_s = is_onehot(ring_in);
        // prev is one-hot outside HUNT, so a match implies a one-hot sample there.
        match_s     = (ring_in == expect_s);
        good_inc_s  = good_cnt_q + GOOD_W'(1);
    end

    // Next-state and next-output logic; everything holds when en is low.
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        good_cnt_d  = good_cnt_q;
        idx_d       = idx_q;
        onehot_ok_d = onehot_ok_q;
        locked_d    = locked_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        seq_err_s   = 1'b0;
        if (en) begin
            onehot_ok_d = sample_oh_s;
            if (sample_oh_s) begin
                idx_d = onehot_to_idx(ring_in);
            end else begin
                idx_d = idx_q;
            end
            case (state_q)
                HUNT: begin
                    if (sample_oh_s) begin
                        prev_d     = ring_in;
                        good_cnt_d = {GOOD_W{1'b0}};
                        state_d    = TRACK;
                    end else begin
                        state_d    = HUNT;
                    end
                end
                TRACK: begin
                    if (match_s) begin
                        prev_d     = ring_in;
                        good_cnt_d = good_inc_s;
                        if (good_inc_s == GOOD_W'(LOCK_CNT)) begin
                            state_d = LOCKED;
                        end else begin
                            state_d = TRACK;
                        end
                    end else if (sample_oh_s) begin
                        // Valid but out of sequence: restart the run from here.
                        prev_d     = ring_in;
                        good_cnt_d = {GOOD_W{1'b0}};
                        state_d    = TRACK;
                    end else begin
                        state_d    = HUNT;
                    end
                end
                LOCKED: begin
                    if (match_s) begin
                        prev_d  = ring_in;
                        state_d = LOCKED;
                    end else begin
                        // Includes a stalled (repeated) word.
                        seq_err_s = 1'b1;
                        if (sample_oh_s) begin
                            prev_d     = ring_in;
                            good_cnt_d = {GOOD_W{1'b0}};
                            state_d    = TRACK;
                        end else begin
                            state_d    = HUNT;
                        end
                    end
                end
                default: begin
                    prev_d     = {WIDTH{1'b0}};
                    good_cnt_d = {GOOD_W{1'b0}};
                    state_d    = HUNT;
                end
            endcase
            locked_d    = (state_d == LOCKED);
            err_pulse_d = seq_err_s;
            if (clr_err) begin
                err_cnt_d = {ERR_W{1'b0}};
            end else if (seq_err_s && (err_cnt_q != {ERR_W{1'b1}})) begin
                err_cnt_d = err_cnt_q + ERR_W'(1);
            end else begin
                err_cnt_d = err_cnt_q;
            end
        end else begin
            err_pulse_d = 1'b0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= HUNT;
            prev_q      <= {WIDTH{1'b0}};
            good_cnt_q  <= {GOOD_W{1'b0}};
            idx_q       <= {IDX_W{1'b0}};
            onehot_ok_q <= 1'b0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= {ERR_W{1'b0}};
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            good_cnt_q  <= good_cnt_d;
            idx_q       <= idx_d;
            onehot_ok_q <= onehot_ok_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign idx       = idx_q;
    assign onehot_ok = onehot_ok_q;
    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ring_monitor.sv
// tb_ring_monitor
// Scoreboard bench for ring_monitor (WIDTH=4, LOCK_CNT=2, ERR_W=8). A driver
// applies directed and random samples, runs a reference model written from
// the behavioural rules, and queues the expected outputs; a monitor pops one
// expectation per clock and compares it with the DUT outputs.
module tb_ring_monitor;

    localparam int WIDTH    = 4;
    localparam int LOCK_CNT = 2;
    localparam int ERR_W    = 8;
    localparam int ERR_MAX  = (1 << ERR_W) - 1;

    logic             clk;
    logic             rst;
    logic             en;
    logic [WIDTH-1:0] ring_in;
    logic             clr_err;
    logic [1:0]       idx;
    logic             onehot_ok;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_cnt;

    ring_monitor #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .ring_in   (ring_in),
        .clr_err   (clr_err),
        .idx       (idx),
        .onehot_ok (onehot_ok),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]       idx;
        logic             oh;
        logic             lk;
        logic             ep;
        logic [ERR_W-1:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passes = 0;
    int   pushed = 0;
    int   popped = 0;

    // Reference model: 0 = hunting, 1 = tracking, 2 = locked.
    int m_state, m_prev, m_good, m_idx, m_oh, m_lk, m_ep, m_cnt;
    int drv_word;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    endtask

    function automatic int rotl(input int p);
        return ((p * 2) % (1 << WIDTH)) + (p / (1 << (WIDTH - 1)));
    endfunction

    function automatic bit one_hot(input int w);
        int n;
        n = 0;
        for (int i = 0; i < WIDTH; i++) if (w == (1 << i)) n++;
        return n == 1;
    endfunction

    function automatic int idx_of(input int w);
        for (int i = 0; i < WIDTH; i++) if (w == (1 << i)) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_state = 0; m_prev = 0; m_good = 0;
        m_idx = 0; m_oh = 0; m_lk = 0; m_ep = 0; m_cnt = 0;
    endtask

    task automatic model_step(input bit e, input int r, input bit c);
        exp_t x;
        bit   oh;
        bit   ok_step;
        m_ep = 0;
        if (e) begin
            oh      = one_hot(r);
            ok_step = oh && (m_state != 0) && (r == rotl(m_prev));
            if (m_state == 0) begin
                if (oh) begin m_prev = r; m_good = 0; m_state = 1; end
            end else if (m_state == 1) begin
                if (ok_step) begin
                    m_prev = r; m_good = m_good + 1;
                    if (m_good == LOCK_CNT) m_state = 2;
                end else if (oh) begin
                    m_prev = r; m_good = 0;
                end else begin
                    m_state = 0;
                end
            end else begin
                if (ok_step) begin
                    m_prev = r;
                end else begin
                    m_ep = 1;
                    if (m_cnt < ERR_MAX) m_cnt = m_cnt + 1;
                    if (oh) begin m_prev = r; m_good = 0; m_state = 1; end
                    else m_state = 0;
                end
            end
            if (c) m_cnt = 0;
            m_oh = oh;
            if (oh) m_idx = idx_of(r);
            m_lk = (m_state == 2);
        end
        x.idx = 2'(m_idx);
        x.oh  = 1'(m_oh);
        x.lk  = 1'(m_lk);
        x.ep  = 1'(m_ep);
        x.cnt = ERR_W'(m_cnt);
        sb_q.push_back(x);
        pushed++;
    endtask

    // One clock: drive at the falling edge, model the rising edge.
    task automatic cyc(input bit e, input int r, input bit c);
        @(negedge clk);
        en      = e;
        ring_in = WIDTH'(r);
        clr_err = c;
        @(posedge clk);
        model_step(e, r, c);
    endtask

    // Monitor: one expectation per clock, compared just after the edge.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (rst && sb_q.size() > 0) begin
            x = sb_q.pop_front();
            popped++;
            chk("idx",       int'(idx),       int'(x.idx));
            chk("onehot_ok", int'(onehot_ok), int'(x.oh));
            chk("locked",    int'(locked),    int'(x.lk));
            chk("err_pulse", int'(err_pulse), int'(x.ep));
            chk("err_cnt",   int'(err_cnt),   int'(x.cnt));
        end
    end

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_idx"},       int'(idx),       0);
        chk({tag, "_onehot_ok"}, int'(onehot_ok), 0);
        chk({tag, "_locked"},    int'(locked),    0);
        chk({tag, "_err_pulse"}, int'(err_pulse), 0);
        chk({tag, "_err_cnt"},   int'(err_cnt),   0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int w, pick;
        rst = 1'b0; en = 1'b0; ring_in = '0; clr_err = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_zero_outputs("reset");
        rst = 1'b1;

        // Lock acquisition.
        cyc(1, 0, 0); cyc(1, 0, 0);
        cyc(1, 1, 0); cyc(1, 2, 0); cyc(1, 4, 0); cyc(1, 8, 0);
        // Sequence error while locked, then relock.
        cyc(1, 1, 0); cyc(1, 2, 0); cyc(1, 8, 0);
        cyc(1, 1, 0); cyc(1, 2, 0);
        // Invalid word while locked, then relock.
        cyc(1, 6, 0);
        cyc(1, 1, 0); cyc(1, 2, 0); cyc(1, 4, 0);
        // Enable gating, then a stalled word.
        for (int i = 0; i < 5; i++) cyc(0, $urandom_range(0, 15), 0);
        cyc(1, 4, 0);
        // Relock, then asynchronous reset between edges (err_cnt is 3 here).
        cyc(1, 8, 0); cyc(1, 1, 0);
        @(negedge clk);
        en = 1'b0;
        #2 rst = 1'b0;
        #1 chk_zero_outputs("async_reset");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        // Full relock sequence after reset.
        cyc(1, 1, 0); cyc(1, 2, 0); cyc(1, 4, 0);

        // Saturation: one stall error per relock, 256 times.
        w = 4;
        for (int i = 0; i < 256; i++) begin
            cyc(1, w, 0);
            w = rotl(w); cyc(1, w, 0);
            w = rotl(w); cyc(1, w, 0);
        end
        // Error with clear on the same edge.
        cyc(1, w, 1);
        w = rotl(w); cyc(1, w, 0);
        w = rotl(w); cyc(1, w, 0);

        // Random mix: mostly correct rotations, with faults and clears.
        drv_word = w;
        for (int i = 0; i < 2000; i++) begin
            pick = $urandom_range(0, 99);
            if (pick < 70)      drv_word = rotl(drv_word);
            else if (pick < 80) drv_word = 1 << $urandom_range(0, WIDTH - 1);
            else if (pick < 88) drv_word = $urandom_range(0, 15);
            if (drv_word == 0 && pick >= 88) drv_word = 1;
            cyc(($urandom_range(0, 3) != 0), drv_word, ($urandom_range(0, 49) == 0));
            if (!one_hot(drv_word)) drv_word = 1;
        end

        @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
        chk("sb_pops", popped, pushed);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
